uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the downstream stage of the UART transmitter. It consumes the serial `tx` line and recovers parallel bytes.
- Mid-bit sampling driven by a per-bit clock-count timer. Flags stop-bit errors and rejects glitch starts.
- Output is a one-cycle valid strobe plus a held data byte, consumed by the system-side logic.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 8; bench uses 16.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- rx  input  1  serial line, idle high, asynchronous to clk
- data_out  output  8  last correctly framed byte, held until overwritten
- data_valid  output  1  one-cycle pulse: data_out just updated
- framing_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset values:
  - data_out = 8'h00; data_valid = 0; framing_err = 0; busy = 0; state = IDLE.
  - Synchronizer flops reset to 1, so no false start is seen on reset release.
- Input conditioning: two-flop synchronizer on rx (rx_s). All decisions use rx_s, giving 2 cycles of fixed input latency.
- Timer: bit counter 0..CLKS_PER_BIT-1. Bit index 0..7. Both clear on every state entry.
- IDLE:
  - busy = 0.
  - When rx_s == 0, go to START with timer = 0 and busy = 1.
- START:
  - When the timer reaches CLKS_PER_BIT/2 - 1 (integer division), sample rx_s.
  - Sample 0: go to DATA with timer = 0.
  - Sample 1: glitch. Go to IDLE; no strobe, no error.
- DATA:
  - Each time the timer reaches CLKS_PER_BIT-1, shift rx_s into shift_reg, LSB first: bit0 is received first, shift_reg[i] is bit index i.
  - After index 7 is captured, go to STOP with timer = 0.
- STOP:
  - When the timer reaches CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: data_out <= shift_reg and data_valid = 1 for one cycle, in the cycle after the sample. Go to IDLE.
  - Sample 0: framing_err = 1 for one cycle. data_out is unchanged. Go to WAIT_HIGH.
- WAIT_HIGH (break/line-low recovery):
  - busy stays 1.
  - Go to IDLE only when rx_s == 1. A continuously low line produces exactly one framing_err, not repeated frames.
- Return to IDLE happens at stop-bit mid-point. A back-to-back start edge half a bit later must be caught (no dead time beyond 1 cycle).
- data_valid and framing_err are never high in the same cycle.
- No receive buffer. A new valid frame overwrites data_out regardless of whether the consumer read it; overrun is not flagged.
- Async reset asserted mid-frame: all state and outputs go to reset values immediately.
  - On release, a line still low mid-frame is treated as a new start edge. The frame is then rejected by the stop check or discarded, per the rules above.
- Sampling-point accuracy: each sample is within ±1 cycle of ideal bit centre, plus 2 cycles of synchronizer delay. Tolerates ±3% baud mismatch at CLKS_PER_BIT >= 16.

Test Plan (CLKS_PER_BIT = 16, 10 ns clk; bench serializer drives rx at 16 clks/bit):
- Reset: hold rst = 0 for 3 cycles with rx = 1, then release and idle 50 cycles -> data_out = 00, busy = 0, no strobes.
- Single frame 0xA5, then single frame 0x3C:
  - Each gives exactly one data_valid pulse; data_out = A5, then 3C.
  - Pulse lands 2 + 8 + 9*16 + 1 cycles (±1) after the start-bit falling edge.
  - busy falls in the same cycle as the pulse.
- Back-to-back 0xFF then 0x00, no idle gap -> two data_valid pulses, data_out = FF then 00, no framing_err.
- Glitch: rx low for 4 cycles, then high -> busy pulses high, returns to 0 within 8 cycles; no data_valid, no framing_err.
- Framing error: send 0x55 with stop bit forced 0, hold rx low 100 more cycles, then release:
  - exactly one framing_err pulse; data_out keeps its previous value; busy stays 1 until rx returns high.
  - A following 0x81 frame is received correctly.
- Reset mid-frame: assert rst at bit 4 of 0xC3 -> outputs clear immediately; no data_valid for that frame. A following 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling.
//
// The receiver synchronizes rx and detects a start edge. It confirms the start
// bit at its half-bit point, then samples the eight data bits (LSB first) and
// the stop bit one bit-time apart. A good frame updates data_out and pulses
// data_valid. A low stop bit pulses framing_err, and the receiver then waits
// for the line to return high before it looks for another start edge.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   rx           serial line, idle high, asynchronous to clk
//   data_out     last correctly framed byte, held until overwritten
//   data_valid   one-cycle pulse when data_out has just been updated
//   framing_err  one-cycle pulse when the stop bit was sampled low
//   busy         high from start detection until return to IDLE
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | timing to mid start bit; high there means a glitch
// DATA      | sampling 8 data bits, one per bit-time
// STOP      | timing to mid stop bit, then strobe or flag an error
// WAIT_HIGH | stop bit was low; hold off until the line returns high

module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       framing_err,
   output logic       busy
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t          state;
   logic            rx_m;
   logic            rx_s;
   logic [TW-1:0]   timer;
   logic [2:0]      bit_idx;
   logic [7:0]      shift_reg;

   // Both flops reset high so that releasing reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         timer       <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         framing_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         data_valid  <= 1'b0;
         framing_err <= 1'b0;
         case (state)
            IDLE: begin
               busy    <= 1'b0;
               timer   <= '0;
               bit_idx <= '0;
               if (!rx_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (timer == T_HALF) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  if (!rx_s) begin
                     state <= DATA;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DATA: begin
               if (timer == T_FULL) begin
                  timer              <= '0;
                  shift_reg[bit_idx] <= rx_s;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            STOP: begin
               if (timer == T_FULL) begin
                  timer <= '0;
                  if (rx_s) begin
                     data_out   <= shift_reg;
                     data_valid <= 1'b1;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     framing_err <= 1'b1;
                     state       <= WAIT_HIGH;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            WAIT_HIGH: begin
               timer <= '0;
               if (rx_s) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       framing_err;
   logic       busy;

   int tests_run = 0;
   int tests_failed = 0;

   int cyc = 0;
   int dv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;
   int busy_cyc = 0;
   int last_dv_cyc = 0;
   logic [7:0] dv_data = 8'h00;
   logic [7:0] prev_dv_data = 8'h00;
   logic dv_busy = 1'b0;
   logic dv_prev_busy = 1'b0;
   logic prev_busy = 1'b0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .framing_err (framing_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (data_valid) begin
         dv_cnt++;
         last_dv_cyc = cyc;
         prev_dv_data = dv_data;
         dv_data = data_out;
         dv_busy = busy;
         dv_prev_busy = prev_busy;
      end
      if (framing_err) fe_cnt++;
      if (data_valid && framing_err) both_cnt++;
      if (busy) busy_cyc++;
      prev_busy = busy;
   end

   // Called on a negedge; returns on the negedge that ends the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int sc);
      rx = 1'b0;
      sc = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (50) @(negedge clk);
      tests_run++;
      if (data_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_data_out: got %h want 00", data_out);
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
      tests_run++;
      if (dv_cnt !== 0 || fe_cnt !== 0) begin
         tests_failed++;
         $display("FAIL reset_strobes: dv %0d fe %0d want 0 0", dv_cnt, fe_cnt);
      end
   endtask

   task automatic test_single(input logic [7:0] d);
      int dv0, fe0, sc, lat;
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(d, 1'b1, sc);
      repeat (20) @(negedge clk);
      tests_run++;
      if (dv_cnt - dv0 !== 1 || fe_cnt - fe0 !== 0) begin
         tests_failed++;
         $display("FAIL single_count_%h: dv %0d fe %0d want 1 0", d, dv_cnt - dv0, fe_cnt - fe0);
      end
      tests_run++;
      if (data_out !== d || dv_data !== d) begin
         tests_failed++;
         $display("FAIL single_data: got %h (at pulse %h) want %h", data_out, dv_data, d);
      end
      lat = last_dv_cyc - sc;
      tests_run++;
      if (lat < 154 || lat > 156) begin
         tests_failed++;
         $display("FAIL single_latency_%h: got %0d want 155 +-1", d, lat);
      end
      tests_run++;
      if (dv_busy !== 1'b0 || dv_prev_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_busy_fall_%h: busy at pulse %b before %b want 0 1", d, dv_busy, dv_prev_busy);
      end
   endtask

   task automatic test_glitch;
      int dv0, fe0, b0;
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      b0 = busy_cyc;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      tests_run++;
      if (busy_cyc - b0 < 1) begin
         tests_failed++;
         $display("FAIL glitch_busy_pulse: busy high %0d cycles want >0", busy_cyc - b0);
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL glitch_busy_return: got %b want 0", busy);
      end
      tests_run++;
      if (dv_cnt - dv0 !== 0 || fe_cnt - fe0 !== 0) begin
         tests_failed++;
         $display("FAIL glitch_strobes: dv %0d fe %0d want 0 0", dv_cnt - dv0, fe_cnt - fe0);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_framing;
      int dv0, fe0, sc;
      logic [7:0] prev;
      prev = data_out;
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(8'h55, 1'b0, sc);
      repeat (100) @(negedge clk);
      tests_run++;
      if (fe_cnt - fe0 !== 1 || dv_cnt - dv0 !== 0) begin
         tests_failed++;
         $display("FAIL framing_count: fe %0d dv %0d want 1 0", fe_cnt - fe0, dv_cnt - dv0);
      end
      tests_run++;
      if (data_out !== 8'h3C || prev !== 8'h3C) begin
         tests_failed++;
         $display("FAIL framing_data_held: got %h want 3c", data_out);
      end
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL framing_busy_low_line: got %b want 1", busy);
      end
      rx = 1'b1;
      repeat (6) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL framing_busy_release: got %b want 0", busy);
      end
      repeat (20) @(negedge clk);
      test_single(8'h81);
   endtask

   task automatic test_reset_mid_frame;
      int dv0, fe0;
      logic [7:0] d;
      d = 8'hC3;
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_busy_before: got %b want 1", busy);
      end
      rx = d[4];
      rst = 1'b0;
      #1;
      tests_run++;
      if (data_out !== 8'h00 || busy !== 1'b0 || data_valid !== 1'b0 || framing_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_clear: data %h busy %b dv %b fe %b want 00 0 0 0",
                  data_out, busy, data_valid, framing_err);
      end
      repeat (CPB) @(negedge clk);
      rx = d[5];
      repeat (CPB) @(negedge clk);
      rx = d[6];
      rst = 1'b1;
      repeat (CPB) @(negedge clk);
      rx = d[7];
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB + 40) @(negedge clk);
      tests_run++;
      if (dv_cnt - dv0 !== 0 || fe_cnt - fe0 !== 0 || data_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL midrst_no_frame: dv %0d fe %0d data %h want 0 0 00",
                  dv_cnt - dv0, fe_cnt - fe0, data_out);
      end
      test_single(8'h5A);
   endtask

   task automatic test_back_to_back;
      int dv0, fe0, sc;
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(8'hFF, 1'b1, sc);
      send_frame(8'h00, 1'b1, sc);
      repeat (30) @(negedge clk);
      tests_run++;
      if (dv_cnt - dv0 !== 2 || fe_cnt - fe0 !== 0) begin
         tests_failed++;
         $display("FAIL b2b_count: dv %0d fe %0d want 2 0", dv_cnt - dv0, fe_cnt - fe0);
      end
      tests_run++;
      if (prev_dv_data !== 8'hFF || dv_data !== 8'h00 || data_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL b2b_data: first %h second %h out %h want ff 00 00",
                  prev_dv_data, dv_data, data_out);
      end
   endtask

   initial begin
      rst = 1'b0;
      rx = 1'b1;
      @(negedge clk);
      test_reset();
      test_single(8'hA5);
      test_single(8'h3C);
      test_glitch();
      test_framing();
      test_reset_mid_frame();
      test_back_to_back();
      tests_run++;
      if (both_cnt !== 0) begin
         tests_failed++;
         $display("FAIL strobe_exclusive: both high %0d cycles want 0", both_cnt);
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
